fft_frame_ctrl: RTL and testbench

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

---
 rtl/dsp_pkg.sv | 14 +
 rtl/fft_frame_ctrl.sv | 144 ++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_pkg.sv
// Shared DSP definitions: frame-controller state encoding and default frame/word sizes.
package dsp_pkg;

    localparam int DEF_FFT_LEN = 1024;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_USEDW_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_FILL = 2'd1,
        ST_STREAM    = 2'd2
    } fft_state_e;

endpackage

// File: rtl/fft_frame_ctrl.sv
// FFT frame controller: holds off until a whole frame sits in the show-ahead FIFO, then
// streams it to the FFT sink with sop/eop framing. `FFT_FRAME_STATS_EN adds frame_cnt/ovf_cnt.
//
// Sink handshake: a word moves when fft_valid and fft_ready are both high in the same cycle
// (ready latency 0); the FIFO is popped combinationally on that same cycle, and while valid
// is high and ready low the offered word and its framing flags stay unchanged.
module fft_frame_ctrl
    import dsp_pkg::*;
#(
    parameter int  FFT_LEN = DEF_FFT_LEN,
    parameter int  DATA_W  = DEF_DATA_W,
    parameter int  USEDW_W = DEF_USEDW_W,
    localparam int IDX_W   = $clog2(FFT_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [USEDW_W-1:0] fifo_usedw,
    input  logic               fifo_empty,
    input  logic               fifo_full,
    input  logic [DATA_W-1:0]  fifo_q,
    output logic               fifo_rdreq,
    input  logic               fft_ready,
    output logic               fft_valid,
    output logic               fft_sop,
    output logic               fft_eop,
    output logic [DATA_W-1:0]  fft_data,
    output logic [IDX_W-1:0]   sample_idx,
    output logic               busy,
    output fft_state_e         state_dbg
`ifdef FFT_FRAME_STATS_EN
    ,
    output logic [15:0]        frame_cnt,
    output logic [15:0]        ovf_cnt
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_LEN - 1);

    fft_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             frame_buffered;
    logic             xfer;

    // Only start once a full frame is buffered, so the frame can never underrun on its own data.
    assign frame_buffered = (32'(fifo_usedw) >= 32'(FFT_LEN));
    assign xfer           = fifo_rdreq;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_WAIT_FILL;
                end
            end
            ST_WAIT_FILL: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (frame_buffered) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // en is only honoured at the frame boundary; a started frame always completes.
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = en ? ST_WAIT_FILL : ST_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        fft_valid  = 1'b0;
        fft_sop    = 1'b0;
        fft_eop    = 1'b0;
        fifo_rdreq = 1'b0;
        if (state_q == ST_STREAM) begin
            fft_valid  = !fifo_empty;
            fft_sop    = !fifo_empty && (idx_q == '0);
            fft_eop    = !fifo_empty && (idx_q == LAST_IDX);
            fifo_rdreq = !fifo_empty && fft_ready;
        end
    end

    assign fft_data   = fifo_q;
    assign sample_idx = idx_q;
    assign busy       = (state_q != ST_IDLE);
    assign state_dbg  = state_q;

`ifdef FFT_FRAME_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    // frame_cnt wraps naturally; ovf_cnt sticks at all-ones.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        ovf_cnt_d   = ovf_cnt_q;
        if (xfer && fft_eop) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if (fifo_full && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            ovf_cnt_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign ovf_cnt   = ovf_cnt_q;
`else
    logic unused_fifo_full;
    assign unused_fifo_full = fifo_full;
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl (FFT_LEN=8): FIFO model, frame-level reference model,
// per-cycle compare and directed scenarios. Define FFT_FRAME_STATS_EN to also check the counters.
module tb_fft_frame_ctrl;
    import dsp_pkg::*;

    localparam int FFT_LEN = 8;
    localparam int DATA_W  = 32;
    localparam int USEDW_W = 11;
    localparam int M_IDLE   = 0;
    localparam int M_WAIT   = 1;
    localparam int M_STREAM = 2;

    logic               clk = 1'b0;
    logic               rst, en, fifo_empty, fifo_full, fft_ready;
    logic               fifo_rdreq, fft_valid, fft_sop, fft_eop, busy;
    logic [USEDW_W-1:0] fifo_usedw;
    logic [DATA_W-1:0]  fifo_q, fft_data;
    logic [2:0]         sample_idx;
    fft_state_e         state_dbg;
`ifdef FFT_FRAME_STATS_EN
    logic [15:0]        frame_cnt, ovf_cnt;
`endif

    fft_frame_ctrl #(.FFT_LEN(FFT_LEN), .DATA_W(DATA_W), .USEDW_W(USEDW_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_usedw (fifo_usedw),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fifo_q     (fifo_q),
        .fifo_rdreq (fifo_rdreq),
        .fft_ready  (fft_ready),
        .fft_valid  (fft_valid),
        .fft_sop    (fft_sop),
        .fft_eop    (fft_eop),
        .fft_data   (fft_data),
        .sample_idx (sample_idx),
        .busy       (busy),
        .state_dbg  (state_dbg)
`ifdef FFT_FRAME_STATS_EN
        ,
        .frame_cnt  (frame_cnt),
        .ovf_cnt    (ovf_cnt)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bench state ----------------
    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic [2:0]  idx;
        logic        sop;
        logic        eop;
    } xfer_t;

    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    logic [DATA_W-1:0] fifo_mem[$];
    logic [DATA_W-1:0] exp_q[$];
    xfer_t             xlog[$];
    bit                usedw_ovr = 1'b0;
    logic [USEDW_W-1:0] usedw_val = '0;

    // reference model: frame phase, position within frame, stats
    bit          model_valid = 1'b0;
    int          m_phase = M_IDLE;
    int          m_pos = 0;
    int          frames_done = 0;
    logic [15:0] m_fcnt = '0;
    logic [15:0] m_ovf = '0;

    // values sampled mid-cycle, applied at the following edge
    bit s_rdreq, s_xfer, s_en, s_rst, s_full;
    logic [USEDW_W-1:0] s_usedw;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fifo_drive();
        fifo_empty = (fifo_mem.size() == 0);
        fifo_q     = fifo_empty ? 32'hBAD0_0000 : fifo_mem[0];
        fifo_usedw = usedw_ovr ? usedw_val : USEDW_W'(fifo_mem.size());
    endtask

    task automatic push_words(logic [31:0] first, int n);
        for (int i = 0; i < n; i++) begin
            fifo_mem.push_back(first + 32'(i));
            exp_q.push_back(first + 32'(i));
        end
        fifo_drive();
    endtask

    // ---------------- compare (mid-cycle) ----------------
    task automatic cycle_check();
        logic        exp_valid, exp_xfer;
        logic [31:0] w;
        exp_valid = (m_phase == M_STREAM) && (fifo_mem.size() != 0);
        exp_xfer  = exp_valid && fft_ready;
        if (model_valid) begin
            chk("valid", 32'(fft_valid), 32'(exp_valid));
            chk("rdreq", 32'(fifo_rdreq), 32'(exp_xfer));
            chk("sop", 32'(fft_sop), 32'(exp_valid && (m_pos == 0)));
            chk("eop", 32'(fft_eop), 32'(exp_valid && (m_pos == FFT_LEN - 1)));
            chk("busy", 32'(busy), 32'(m_phase != M_IDLE));
            chk("idx", 32'(sample_idx), 32'(m_pos));
            chk("data_passthru", fft_data, fifo_q);
            if (exp_xfer) begin
                if (exp_q.size() == 0) begin
                    chk("exp_q_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    w = exp_q.pop_front();
                    chk("data_order", fft_data, w);
                end
            end
`ifdef FFT_FRAME_STATS_EN
            chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
            chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
`endif
        end
        if (fft_valid && fft_ready) begin
            xlog.push_back('{cyc, fft_data, sample_idx, fft_sop, fft_eop});
        end
        s_rdreq = fifo_rdreq;
        s_xfer  = exp_xfer;
        s_en    = en;
        s_rst   = rst;
        s_full  = fifo_full;
        s_usedw = fifo_usedw;
    endtask

    // ---------------- FIFO + model update (just after the edge) ----------------
    task automatic cycle_update();
        if (s_rdreq) begin
            chk("pop_nonempty", 32'(fifo_mem.size() != 0), 32'd1);
            if (fifo_mem.size() != 0) begin
                void'(fifo_mem.pop_front());
            end
        end
        if (s_rst) begin
            model_valid = 1'b1;
            m_phase = M_IDLE;
            m_pos   = 0;
            m_fcnt  = '0;
            m_ovf   = '0;
        end else begin
            if (s_full && m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
            case (m_phase)
                M_IDLE:   if (s_en) m_phase = M_WAIT;
                M_WAIT:   if (!s_en) m_phase = M_IDLE;
                          else if (int'(s_usedw) >= FFT_LEN) m_phase = M_STREAM;
                default: begin
                    if (s_xfer) begin
                        if (m_pos == FFT_LEN - 1) begin
                            m_pos = 0;
                            m_fcnt = m_fcnt + 16'd1;
                            frames_done++;
                            m_phase = s_en ? M_WAIT : M_IDLE;
                        end else begin
                            m_pos++;
                        end
                    end
                end
            endcase
        end
        fifo_drive();
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        cycle_check();
        @(posedge clk);
        #1;
        cycle_update();
    endtask

    // ---------------- bounded waits ----------------
    task automatic wait_idx(int idx, bit want_valid, int budget);
        int n = 0;
        while (!((fft_valid == want_valid) && busy && (int'(sample_idx) == idx)) && n < budget) begin
            tick();
            n++;
        end
        chk("wait_idx_timeout", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_frames(int target, int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin
            tick();
            n++;
        end
        chk("wait_frames_timeout", 32'(n < budget), 32'd1);
    endtask

    // Literal expectations for one logged frame starting at xlog[base].
    task automatic check_frame(int base, logic [31:0] first, bit consec);
        chk("frame_len", 32'(xlog.size() >= base + FFT_LEN), 32'd1);
        if (xlog.size() < base + FFT_LEN) return;
        for (int i = 0; i < FFT_LEN; i++) begin
            chk("frm_data", xlog[base+i].data, first + 32'(i));
            chk("frm_idx", 32'(xlog[base+i].idx), 32'(i));
            chk("frm_sop", 32'(xlog[base+i].sop), 32'(i == 0));
            chk("frm_eop", 32'(xlog[base+i].eop), 32'(i == FFT_LEN - 1));
            if (consec) chk("frm_consec", 32'(xlog[base+i].cyc - xlog[base].cyc), 32'(i));
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int base;
        rst = 1'b1; en = 1'b0; fft_ready = 1'b1; fifo_full = 1'b0;
        fifo_drive();
        #1;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(fft_valid), 32'd0);
        chk("rst_idx", 32'(sample_idx), 32'd0);
        chk("rst_rdreq", 32'(fifo_rdreq), 32'd0);
        rst = 1'b0;

        // fill threshold, then one gap-free frame
        en = 1'b1;
        push_words(32'h1, 7);
        repeat (4) tick();
        chk("fill7_valid", 32'(fft_valid), 32'd0);
        chk("fill7_state", 32'(state_dbg), 32'(ST_WAIT_FILL));
        chk("fill7_busy", 32'(busy), 32'd1);
        base = xlog.size();
        push_words(32'h8, 1);
        tick();
        chk("start_valid", 32'(fft_valid), 32'd1);
        chk("start_sop", 32'(fft_sop), 32'd1);
        chk("start_data", fft_data, 32'h1);
        chk("start_idx", 32'(sample_idx), 32'd0);
        wait_frames(1, 40);
        check_frame(base, 32'h1, 1'b1);

        // backpressure at idx 4
        base = xlog.size();
        push_words(32'h11, 8);
        wait_idx(4, 1'b1, 30);
        fft_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("stall_valid", 32'(fft_valid), 32'd1);
            chk("stall_idx", 32'(sample_idx), 32'd4);
            chk("stall_data", fft_data, 32'h15);
            chk("stall_rdreq", 32'(fifo_rdreq), 32'd0);
        end
        fft_ready = 1'b1;
        wait_frames(2, 40);
        check_frame(base, 32'h11, 1'b0);

        // en dropped mid-frame: frame completes, then idle
        base = xlog.size();
        push_words(32'h21, 8);
        wait_idx(2, 1'b1, 30);
        en = 1'b0;
        wait_frames(3, 40);
        check_frame(base, 32'h21, 1'b1);
        chk("en_off_busy", 32'(busy), 32'd0);
        chk("en_off_state", 32'(state_dbg), 32'(ST_IDLE));

        // reset mid-frame; the word offered at the reset edge is still popped
        en = 1'b1;
        push_words(32'h31, 8);
        wait_idx(5, 1'b1, 30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_valid", 32'(fft_valid), 32'd0);
        chk("mrst_sop", 32'(fft_sop), 32'd0);
        chk("mrst_eop", 32'(fft_eop), 32'd0);
        chk("mrst_rdreq", 32'(fifo_rdreq), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_idx", 32'(sample_idx), 32'd0);
        base = xlog.size();
        push_words(32'h39, 6);
        wait_frames(4, 40);
        check_frame(base, 32'h37, 1'b1);

        // FIFO runs dry mid-frame (fill level forced to look full)
        base = xlog.size();
        usedw_ovr = 1'b1;
        usedw_val = 11'd8;
        push_words(32'h41, 3);
        wait_idx(3, 1'b0, 30);
        repeat (3) begin
            tick();
            chk("dry_valid", 32'(fft_valid), 32'd0);
            chk("dry_idx", 32'(sample_idx), 32'd3);
            chk("dry_rdreq", 32'(fifo_rdreq), 32'd0);
        end
        usedw_ovr = 1'b0;
        push_words(32'h44, 5);
        wait_frames(5, 40);
        check_frame(base, 32'h41, 1'b0);

        // back-to-back frames: exactly one WAIT_FILL cycle between eop and sop
        base = xlog.size();
        push_words(32'h51, 16);
        wait_frames(7, 60);
        check_frame(base, 32'h51, 1'b1);
        check_frame(base + 8, 32'h59, 1'b1);
        if (xlog.size() >= base + 16) begin
            chk("b2b_gap", 32'(xlog[base+8].cyc - xlog[base+7].cyc), 32'd2);
        end

        // statistics: 3 frames, fifo_full for 4 cycles after a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fifo_full = 1'b1;
        repeat (4) tick();
        fifo_full = 1'b0;
        base = xlog.size();
        push_words(32'h61, 24);
        wait_frames(10, 80);
        check_frame(base, 32'h61, 1'b1);
        check_frame(base + 16, 32'h71, 1'b1);
`ifdef FFT_FRAME_STATS_EN
        chk("stats_frame_cnt", 32'(frame_cnt), 32'd3);
        chk("stats_ovf_cnt", 32'(ovf_cnt), 32'd4);
`endif

        en = 1'b0;
        repeat (4) tick();
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("end_fifo_empty", 32'(fifo_mem.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
